// File: rtl/vic_arbiter.sv
// Vectored-interrupt arbiter: shares the CPU VIRQ/IACK pair between four
// level-held requesters by fixed priority and returns a per-requester ack.
module vic_arbiter #(
  parameter logic [15:0] VEC0    = 16'o000060,
  parameter logic [15:0] VEC1    = 16'o000274,
  parameter logic [15:0] VEC2    = 16'o000100,
  parameter logic [15:0] VEC3    = 16'o000000,
  parameter int unsigned ACK_TMO = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic        wb_clk,
  input  logic        sys_init_n,
  input  logic [3:0]  virq_req,
  input  logic [3:0]  virq_ena,
  output logic [3:0]  virq_ack,
  output logic        cpu_virq,
  output logic [15:0] cpu_ivec,
  input  logic        cpu_iack,
  output logic        spurious
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_REL,
    S_GAP
  } state_t;

  localparam logic [7:0] TMO_LD   = 8'(ACK_TMO);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYC);
  localparam bit         GAP_NONE = (GAP_CYC == 0);

  state_t      state;
  logic [1:0]  win;
  logic [7:0]  tmo_cnt;
  logic [3:0]  gap_cnt;
  logic        iack_old;
  logic [3:0]  eff;
  logic        iack_edge;

  function automatic logic [1:0] win_idx(input logic [3:0] e);
    if (e[0])      return 2'd0;
    else if (e[1]) return 2'd1;
    else if (e[2]) return 2'd2;
    else if (e[3]) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [15:0] vec_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return VEC0;
      2'd1:    return VEC1;
      2'd2:    return VEC2;
      default: return VEC3;
    endcase
  endfunction

  function automatic logic [3:0] ack_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign eff       = virq_req & virq_ena;
  assign iack_edge = cpu_iack & ~iack_old;

  always_ff @(posedge wb_clk) begin
    if (!sys_init_n) begin
      state    <= S_IDLE;
      win      <= 2'd0;
      tmo_cnt  <= 8'd0;
      gap_cnt  <= 4'd0;
      iack_old <= 1'b0;
      cpu_virq <= 1'b0;
      cpu_ivec <= 16'd0;
      virq_ack <= 4'd0;
      spurious <= 1'b0;
    end else begin
      iack_old <= cpu_iack;
      spurious <= 1'b0;
      case (state)
        S_IDLE: begin
          cpu_virq <= 1'b0;
          virq_ack <= 4'd0;
          if (iack_edge) spurious <= 1'b1;
          if (|eff) begin
            win      <= win_idx(eff);
            cpu_ivec <= vec_of(win_idx(eff));
            cpu_virq <= 1'b1;
            state    <= S_REQ;
          end
        end
        // The CPU commits to the vector on its IACK edge, so that wins over a
        // request dropping in the same cycle.
        S_REQ: begin
          if (iack_edge) begin
            cpu_virq <= 1'b0;
            virq_ack <= ack_bit(win);
            tmo_cnt  <= TMO_LD;
            state    <= S_ACK;
          end else if (!eff[win]) begin
            cpu_virq <= 1'b0;
            state    <= S_IDLE;
          end
        end
        // Release watches the raw request so a mask change cannot cut the ack.
        S_ACK: begin
          if (!virq_req[win] || tmo_cnt <= 8'd1) begin
            virq_ack <= 4'd0;
            tmo_cnt  <= 8'd0;
            state    <= S_REL;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        S_REL: begin
          virq_ack <= 4'd0;
          if (iack_edge) spurious <= 1'b1;
          gap_cnt <= GAP_LD;
          state   <= GAP_NONE ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (iack_edge) spurious <= 1'b1;
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= 4'd0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vic_arbiter.sv
// Directed bench for vic_arbiter: expected vector/ack pairs are queued when a
// request is driven and consumed when the arbiter grants and acknowledges.
module tb_vic_arbiter;

  logic        wb_clk = 1'b0;
  logic        sys_init_n;
  logic [3:0]  virq_req;
  logic [3:0]  virq_ena;
  logic [3:0]  virq_ack;
  logic        cpu_virq;
  logic [15:0] cpu_ivec;
  logic        cpu_iack;
  logic        spurious;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] vec;
    logic [3:0]  ack;
  } exp_t;
  exp_t sb[$];

  vic_arbiter dut (
    .wb_clk    (wb_clk),
    .sys_init_n(sys_init_n),
    .virq_req  (virq_req),
    .virq_ena  (virq_ena),
    .virq_ack  (virq_ack),
    .cpu_virq  (cpu_virq),
    .cpu_ivec  (cpu_ivec),
    .cpu_iack  (cpu_iack),
    .spurious  (spurious)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] vec, input logic [3:0] ack);
    exp_t e;
    e.vec = vec;
    e.ack = ack;
    sb.push_back(e);
  endtask

  task automatic check_grant(input string tag);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      check({tag, "_virq"}, 32'(cpu_virq), 32'd1);
      check({tag, "_vec"}, 32'(cpu_ivec), 32'(sb[0].vec));
    end
  endtask

  task automatic check_ack(input string tag);
    exp_t e;
    if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      check({tag, "_ack"}, 32'(virq_ack), 32'(e.ack));
      check({tag, "_virq_low"}, 32'(cpu_virq), 32'd0);
      check({tag, "_vec_held"}, 32'(cpu_ivec), 32'(e.vec));
    end
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (!cpu_virq && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int ack_len;
    sys_init_n = 1'b0;
    virq_req   = 4'b0000;
    virq_ena   = 4'b1111;
    cpu_iack   = 1'b0;
    tick();
    tick();
    check("rst_virq", 32'(cpu_virq), 32'd0);
    check("rst_vec", 32'(cpu_ivec), 32'd0);
    check("rst_ack", 32'(virq_ack), 32'd0);
    check("rst_spur", 32'(spurious), 32'd0);
    sys_init_n = 1'b1;
    tick();

    // Test 1: single keyboard request
    virq_req = 4'b0001;
    push_exp(16'o000060, 4'b0001);
    tick();
    check_grant("t1_grant");
    tick();
    tick();
    cpu_iack = 1'b1;
    tick();
    check_ack("t1");
    virq_req = 4'b0000;
    cpu_iack = 1'b0;
    tick();
    check("t1_ack_fall", 32'(virq_ack), 32'd0);
    virq_req = 4'b0001;
    push_exp(16'o000060, 4'b0001);
    wait_grant(cyc);
    check("t1_spacing", 32'(cyc), 32'd4);
    check_grant("t1_regrant");
    cpu_iack = 1'b1;
    tick();
    check_ack("t1b");
    virq_req = 4'b0000;
    cpu_iack = 1'b0;
    repeat (5) tick();

    // Test 2: priority, no preemption
    virq_req = 4'b0100;
    push_exp(16'o000100, 4'b0100);
    push_exp(16'o000060, 4'b0001);
    tick();
    check_grant("t2_first");
    virq_req = 4'b0101;
    tick();
    check_grant("t2_nopreempt");
    tick();
    check_grant("t2_nopreempt2");
    cpu_iack = 1'b1;
    tick();
    check_ack("t2a");
    virq_req = 4'b0001;
    cpu_iack = 1'b0;
    tick();
    wait_grant(cyc);
    check_grant("t2_second");
    cpu_iack = 1'b1;
    tick();
    check_ack("t2b");
    virq_req = 4'b0000;
    cpu_iack = 1'b0;
    repeat (5) tick();

    // Test 3: cancel before IACK
    virq_req = 4'b0001;
    tick();
    check("t3_raise", 32'(cpu_virq), 32'd1);
    virq_req = 4'b0000;
    tick();
    check("t3_cancel_virq", 32'(cpu_virq), 32'd0);
    check("t3_cancel_ack", 32'(virq_ack), 32'd0);
    check("t3_cancel_spur", 32'(spurious), 32'd0);
    tick();
    check("t3_idle_ack", 32'(virq_ack), 32'd0);
    tick();

    // Test 4: IACK edge coincident with request drop
    virq_req = 4'b0010;
    push_exp(16'o000274, 4'b0010);
    tick();
    check_grant("t4_grant");
    tick();
    virq_req = 4'b0000;
    cpu_iack = 1'b1;
    tick();
    check_ack("t4");
    cpu_iack = 1'b0;
    tick();
    check("t4_ack_fall", 32'(virq_ack), 32'd0);
    check("t4_vec_rel", 32'(cpu_ivec), 32'o000274);
    repeat (5) tick();

    // Test 5: timeout with a stuck request, then an idle spurious IACK
    virq_req = 4'b1000;
    push_exp(16'o000000, 4'b1000);
    tick();
    check_grant("t5_grant");
    cpu_iack = 1'b1;
    tick();
    check_ack("t5");
    cpu_iack = 1'b0;
    ack_len = 0;
    while (virq_ack[3] && ack_len < 40) begin
      ack_len++;
      tick();
    end
    check("t5_ack_len", 32'(ack_len), 32'd16);
    push_exp(16'o000000, 4'b1000);
    wait_grant(cyc);
    check("t5_repres_cyc", 32'(cyc), 32'd4);
    check_grant("t5_repres");
    void'(sb.pop_front());
    virq_req = 4'b0000;
    tick();
    check("t5_cancel", 32'(cpu_virq), 32'd0);
    tick();
    cpu_iack = 1'b1;
    tick();
    check("t5_spur_hi", 32'(spurious), 32'd1);
    check("t5_spur_virq", 32'(cpu_virq), 32'd0);
    cpu_iack = 1'b0;
    tick();
    check("t5_spur_lo", 32'(spurious), 32'd0);
    tick();

    // Test 6: reset while ack is high
    virq_req = 4'b0001;
    push_exp(16'o000060, 4'b0001);
    tick();
    check_grant("t6_grant");
    cpu_iack = 1'b1;
    tick();
    check_ack("t6");
    cpu_iack   = 1'b0;
    sys_init_n = 1'b0;
    tick();
    check("t6_rst_ack", 32'(virq_ack), 32'd0);
    check("t6_rst_virq", 32'(cpu_virq), 32'd0);
    check("t6_rst_vec", 32'(cpu_ivec), 32'd0);
    check("t6_rst_spur", 32'(spurious), 32'd0);
    sys_init_n = 1'b1;
    push_exp(16'o000060, 4'b0001);
    tick();
    check_grant("t6_rereq");
    cpu_iack = 1'b1;
    tick();
    check_ack("t6b");
    virq_req = 4'b0000;
    cpu_iack = 1'b0;
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
